// File: rtl/oscillator_pkg.sv
// Shared types and encodings for the oscillator sequencer and datapath.
package oscillator_pkg;

    typedef enum logic [2:0] {
        ST_SEED,
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WAIT,
        ST_CAPTURE,
        ST_EMIT
    } osc_state_e;

    typedef enum logic [1:0] {
        CLS_INACTIVE,
        CLS_TONE,
        CLS_NOISE
    } voice_class_e;

    localparam logic [1:0] S_OSC_OUT_ZERO  = 2'd0;
    localparam logic [1:0] S_OSC_OUT_ROM   = 2'd1;
    localparam logic [1:0] S_OSC_OUT_NOISE = 2'd2;

    localparam logic S_NOISE_SEED = 1'b0;
    localparam logic S_NOISE_STEP = 1'b1;

    localparam int unsigned OSC_CHOICE_NOISE = 4;
    localparam int unsigned VOICE_CYCLES     = 5;

    // Output-register source for a decoded voice class.
    function automatic logic [1:0] out_select(voice_class_e cls);
        case (cls)
            CLS_TONE:  return S_OSC_OUT_ROM;
            CLS_NOISE: return S_OSC_OUT_NOISE;
            default:   return S_OSC_OUT_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/control_oscillator_if.sv
// Control bundle between the oscillator sequencer and its environment.
interface control_oscillator_if #(
    parameter int unsigned VW = 3
);
    logic          sample_tick;
    logic [VW-1:0] voice_raddr;
    logic          voice_active;
    logic          osc_choice_is_noise;
    logic          phase_we;
    logic [VW-1:0] phase_waddr;
    logic          en_osc_noise;
    logic          s_osc_noise;
    logic          en_osc_out;
    logic [1:0]    s_osc_out;
    logic          sample_valid;
    logic [VW-1:0] sample_voice;
    logic          sample_last;
    logic          busy;
    logic          overrun;

    modport master (
        input  sample_tick, voice_active, osc_choice_is_noise,
        output voice_raddr, phase_we, phase_waddr, en_osc_noise, s_osc_noise,
               en_osc_out, s_osc_out, sample_valid, sample_voice, sample_last,
               busy, overrun
    );

    modport slave (
        output sample_tick, voice_active, osc_choice_is_noise,
        input  voice_raddr, phase_we, phase_waddr, en_osc_noise, s_osc_noise,
               en_osc_out, s_osc_out, sample_valid, sample_voice, sample_last,
               busy, overrun
    );
endinterface

// File: rtl/control_oscillator_voice_counter.sv
// Voice slot counter: clear at frame start, step between voices, flags the last slot.
module voice_counter #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned VW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [VW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + VW'(1);
        end
    end

    assign last = (count == VW'(NUM_VOICES - 1));

endmodule

// File: rtl/control_oscillator.sv
// Per-frame voice sequencer steering the oscillator datapath, five cycles per voice.
module control_oscillator
    import oscillator_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input logic                clk,
    input logic                rst_n,
    control_oscillator_if.master bus
);

    osc_state_e    state;
    voice_class_e  cls;
    logic [VW-1:0] v;
    logic          v_last;
    logic          v_clear;
    logic          v_inc;

    logic          phase_we_q;
    logic [VW-1:0] phase_waddr_q;
    logic          en_osc_noise_q;
    logic          s_osc_noise_q;
    logic          en_osc_out_q;
    logic [1:0]    s_osc_out_q;
    logic          sample_valid_q;
    logic [VW-1:0] sample_voice_q;
    logic          sample_last_q;
    logic          busy_q;
    logic          overrun_q;

    assign v_clear = (state == ST_IDLE) && bus.sample_tick;
    assign v_inc   = (state == ST_EMIT) && !v_last;

    voice_counter #(
        .NUM_VOICES (NUM_VOICES),
        .VW         (VW)
    ) u_voice_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (v_clear),
        .inc   (v_inc),
        .count (v),
        .last  (v_last)
    );

    // Each output is loaded on the edge entering the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_SEED;
            cls            <= CLS_INACTIVE;
            phase_we_q     <= 1'b0;
            phase_waddr_q  <= '0;
            en_osc_noise_q <= 1'b1;
            s_osc_noise_q  <= S_NOISE_SEED;
            en_osc_out_q   <= 1'b0;
            s_osc_out_q    <= S_OSC_OUT_ZERO;
            sample_valid_q <= 1'b0;
            sample_voice_q <= '0;
            sample_last_q  <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            phase_we_q     <= 1'b0;
            en_osc_noise_q <= 1'b0;
            s_osc_noise_q  <= S_NOISE_SEED;
            en_osc_out_q   <= 1'b0;
            s_osc_out_q    <= S_OSC_OUT_ZERO;
            sample_valid_q <= 1'b0;
            sample_last_q  <= 1'b0;
            overrun_q      <= bus.sample_tick && (state != ST_IDLE);

            case (state)
                ST_SEED: state <= ST_IDLE;
                ST_IDLE: begin
                    if (bus.sample_tick) begin
                        state  <= ST_FETCH;
                        busy_q <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    state <= ST_WAIT;
                    if (!bus.voice_active) begin
                        cls <= CLS_INACTIVE;
                    end else if (bus.osc_choice_is_noise) begin
                        cls            <= CLS_NOISE;
                        en_osc_noise_q <= 1'b1;
                        s_osc_noise_q  <= S_NOISE_STEP;
                    end else begin
                        cls <= CLS_TONE;
                    end
                end
                ST_WAIT: begin
                    state         <= ST_CAPTURE;
                    en_osc_out_q  <= 1'b1;
                    s_osc_out_q   <= out_select(cls);
                    phase_we_q    <= (cls == CLS_TONE);
                    phase_waddr_q <= v;
                end
                ST_CAPTURE: begin
                    state          <= ST_EMIT;
                    sample_valid_q <= 1'b1;
                    sample_voice_q <= v;
                    sample_last_q  <= v_last;
                end
                ST_EMIT: begin
                    if (v_last) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_SEED;
            endcase
        end
    end

    // A reset landing in CAPTURE must suppress that cycle's phase write.
    assign bus.phase_we     = phase_we_q & rst_n;
    assign bus.voice_raddr  = v;
    assign bus.phase_waddr  = phase_waddr_q;
    assign bus.en_osc_noise = en_osc_noise_q;
    assign bus.s_osc_noise  = s_osc_noise_q;
    assign bus.en_osc_out   = en_osc_out_q;
    assign bus.s_osc_out    = s_osc_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_voice = sample_voice_q;
    assign bus.sample_last  = sample_last_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_control_oscillator.sv
// Directed bench for control_oscillator with four voice slots.
module tb_control_oscillator;

    localparam int unsigned NV = 4;
    localparam int unsigned W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [NV-1:0] act_cfg;
    logic [NV-1:0] noise_cfg;
    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    control_oscillator_if #(.VW(W)) bus ();

    control_oscillator #(
        .NUM_VOICES (NV),
        .VW         (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Voice-config RAM model: combinational from the held read address.
    always_comb begin
        bus.voice_active        = act_cfg[bus.voice_raddr];
        bus.osc_choice_is_noise = noise_cfg[bus.voice_raddr];
    end

    task automatic test_reset();
        logic [15:0] got;
        rst_n = 1'b0;
        bus.sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {bus.busy, bus.sample_valid, bus.sample_last, bus.overrun, bus.phase_we,
               bus.en_osc_out, bus.s_osc_out, bus.s_osc_noise, bus.voice_raddr,
               bus.phase_waddr, bus.en_osc_noise, 2'b00};
        total++;
        if (got !== 16'h0004) $display("FAIL reset_hold got=%h exp=%h", got, 16'h0004);
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.en_osc_noise, bus.s_osc_noise, bus.busy} !== 3'b100)
            $display("FAIL seed_cycle got=%b exp=100", {bus.en_osc_noise, bus.s_osc_noise, bus.busy});
        else passed++;
        @(negedge clk);
        got = {bus.en_osc_noise, bus.s_osc_noise, bus.en_osc_out, bus.s_osc_out, bus.phase_we,
               bus.phase_waddr, bus.sample_valid, bus.sample_voice, bus.sample_last,
               bus.busy, bus.overrun, bus.voice_raddr};
        total++;
        if (got !== 16'h0000) $display("FAIL idle_after_seed got=%h exp=0000", got);
        else passed++;
    endtask

    task automatic test_all_tone();
        logic [3:0] got, exp;
        act_cfg = 4'hF;
        noise_cfg = 4'h0;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            exp = {(k % 5 == 4) && k >= 4 && k <= 19, (k % 5 == 0) && k >= 5 && k <= 20,
                   k == 20, k >= 1 && k <= 20};
            got = {bus.phase_we, bus.sample_valid, bus.sample_last, bus.busy};
            total++;
            if (got !== exp) $display("FAIL tone_frame k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            if (exp[2]) begin
                total++;
                if (bus.sample_voice !== W'(k / 5 - 1))
                    $display("FAIL tone_voice k=%0d got=%0d exp=%0d", k, bus.sample_voice, k / 5 - 1);
                else passed++;
            end
            if (exp[3]) begin
                total++;
                if (bus.phase_waddr !== W'((k - 4) / 5))
                    $display("FAIL tone_waddr k=%0d got=%0d exp=%0d", k, bus.phase_waddr, (k - 4) / 5);
                else passed++;
            end
            @(posedge clk); #1 bus.sample_tick = 1'b0;
        end
    endtask

    task automatic test_mixed();
        logic [5:0] got, exp;
        logic       in_frame;
        int         voice, p;
        logic [1:0] sel;
        act_cfg = 4'b1011;
        noise_cfg = 4'b0010;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            in_frame = (k >= 1) && (k <= 20);
            voice = in_frame ? (k - 1) / 5 : 0;
            p = in_frame ? (k - 1) % 5 : 9;
            sel = (p != 3) ? 2'd0 : (voice == 1) ? 2'd2 : (voice == 2) ? 2'd0 : 2'd1;
            exp = {p == 2 && voice == 1, p == 2 && voice == 1, p == 3, sel,
                   p == 3 && voice != 1 && voice != 2};
            got = {bus.en_osc_noise, bus.s_osc_noise, bus.en_osc_out, bus.s_osc_out, bus.phase_we};
            total++;
            if (got !== exp) $display("FAIL mixed_strobes k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            if (in_frame) begin
                total++;
                if (bus.voice_raddr !== W'(voice))
                    $display("FAIL mixed_raddr k=%0d got=%0d exp=%0d", k, bus.voice_raddr, voice);
                else passed++;
            end
            @(posedge clk); #1 bus.sample_tick = 1'b0;
        end
    endtask

    task automatic test_overrun();
        logic [3:0] got, exp;
        act_cfg = 4'hF;
        noise_cfg = 4'h0;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            exp = {k == 8, (k % 5 == 0) && k >= 5 && k <= 20, k == 20, k >= 1 && k <= 20};
            got = {bus.overrun, bus.sample_valid, bus.sample_last, bus.busy};
            total++;
            if (got !== exp) $display("FAIL overrun_frame k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk); #1 bus.sample_tick = (k + 1 == 7);
        end
    endtask

    task automatic test_reset_mid_frame();
        act_cfg = 4'hF;
        noise_cfg = 4'h0;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.phase_we !== 1'b1) $display("FAIL capture_pre_reset got=%b exp=1", bus.phase_we);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.phase_we !== 1'b0) $display("FAIL capture_in_reset got=%b exp=0", bus.phase_we);
        else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.en_osc_noise, bus.s_osc_noise, bus.busy, bus.sample_valid} !== 4'b1000)
            $display("FAIL reseed got=%b exp=1000",
                     {bus.en_osc_noise, bus.s_osc_noise, bus.busy, bus.sample_valid});
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.voice_raddr, bus.busy, bus.en_osc_noise, bus.sample_valid, bus.phase_we} !== 6'b0)
            $display("FAIL idle_after_reseed got=%b exp=000000",
                     {bus.voice_raddr, bus.busy, bus.en_osc_noise, bus.sample_valid, bus.phase_we});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, exp;
        int f;
        act_cfg = 4'hF;
        noise_cfg = 4'h0;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            @(negedge clk);
            f = (k >= 21) ? k - 21 : k;
            exp = {1'b0, (f % 5 == 0) && f >= 5 && f <= 20, f == 20, f >= 1 && f <= 20};
            got = {bus.overrun, bus.sample_valid, bus.sample_last, bus.busy};
            total++;
            if (got !== exp) $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp);
            else passed++;
            @(posedge clk); #1 bus.sample_tick = (k + 1 == 21);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sample_tick = 1'b0;
        act_cfg = 4'hF;
        noise_cfg = 4'h0;
        test_reset();
        test_all_tone();
        test_mixed();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_oscillator.md
# control_oscillator

Sequencer for the oscillator datapath. On each 48 kHz `sample_tick` it walks every voice slot in order and, for each voice:
- fetches the voice configuration and stored phase;
- steers the datapath enable/select lines so its output register captures the tone, noise or silence value;
- writes back the advanced phase;
- strobes the finished sample to the downstream mixer.

It sits between the sample-rate timebase, the voice/phase memories and `datapath_oscillator`.

## Interface
Parameters:
- `NUM_VOICES`, 8: voice slots per frame, ≥1.
- `VW`, `$clog2(NUM_VOICES)` (min 1): voice index width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `sample_tick` in 1: one-cycle frame start strobe.
- `voice_raddr` out VW: voice-config RAM and phase RAM read address; 1-cycle synchronous read.
- `voice_active` in 1: config RAM data, voice enabled.
- `osc_choice_is_noise` in 1: from datapath; valid in DECODE.
- `phase_we` out 1: phase RAM write enable; write data is datapath `next_note_phase`.
- `phase_waddr` out VW: phase RAM write address.
- `en_osc_noise` out 1: datapath noise register enable.
- `s_osc_noise` out 1: 0 = load seed, 1 = advance LFSR.
- `en_osc_out` out 1: datapath output register enable.
- `s_osc_out` out 2: 0 = zero, 1 = ROM, 2 = noise.
- `sample_valid` out 1: datapath `out` holds voice `sample_voice`'s sample this cycle.
- `sample_voice` out VW: voice index of the emitted sample.
- `sample_last` out 1: with `sample_valid`, last voice of the frame.
- `busy` out 1: frame in progress.
- `overrun` out 1: one-cycle pulse, tick dropped.

## Operation
States: SEED, IDLE, FETCH, DECODE, WAIT, CAPTURE, EMIT.
- **SEED**: entered on reset. For one cycle drives `en_osc_noise`=1 and `s_osc_noise`=0, then goes to IDLE.
- **IDLE**: on `sample_tick`, sets voice counter v=0 and goes to FETCH.
- **FETCH**: drives `voice_raddr`=v.
- **DECODE**: RAM data is valid. Latches the class: inactive if `!voice_active`, else noise if `osc_choice_is_noise`, else tone.
- **WAIT**: tone: ROM read cycle, no strobes. Noise: `en_osc_noise`=1, `s_osc_noise`=1. Inactive: no strobes.
- **CAPTURE**: `en_osc_out`=1. `s_osc_out` is 1 for tone, 2 for noise, 0 for inactive. Tone only: `phase_we`=1 with `phase_waddr`=v. Noise and inactive phases are not written.
- **EMIT**: `sample_valid`=1, `sample_voice`=v, `sample_last`=(v==NUM_VOICES-1). If last, go to IDLE; otherwise v+1 and go to FETCH.

Rules:
- `voice_raddr` holds v from FETCH through EMIT, so the datapath `note_phase` and ROM address stay stable.
- Every voice takes exactly 5 cycles regardless of class.
- `busy`=1 in FETCH through EMIT.
- All strobes are 0 in any state not listed above.

## Timing
- Reset values: state=SEED, v=0, `voice_raddr`=0, `phase_waddr`=0, `s_osc_out`=0, `s_osc_noise`=0. `busy`, `sample_valid`, `sample_last`, `overrun`, `phase_we`, `en_osc_out` are 0. `en_osc_noise` is 1 during the SEED cycle following reset release.
- Tick in IDLE at cycle t: FETCH at t+1, first `sample_valid` at t+5, last at t+5·NUM_VOICES. IDLE resumes the following cycle.
- `sample_tick` while not IDLE (including SEED and the tick cycle itself when busy): tick dropped, `overrun`=1 next cycle, frame continues unchanged.
- `rst_n`=0 mid-frame: abandon immediately. No phase write occurs that cycle. Next state is SEED.
- v wraps only through IDLE; it never exceeds NUM_VOICES-1.

## Structure
- Shared package (`oscillator_pkg`):
  - state enum;
  - `S_OSC_OUT_ZERO`=0, `S_OSC_OUT_ROM`=1, `S_OSC_OUT_NOISE`=2;
  - `S_NOISE_SEED`=0, `S_NOISE_STEP`=1;
  - `OSC_CHOICE_NOISE`=4;
  - `VOICE_CYCLES`=5.
- Sub-module `voice_counter`: clear/increment/last flag, width VW. The FSM and output decode stay in `control_oscillator`.

## Test plan
- Reset release → one cycle `en_osc_noise`=1, `s_osc_noise`=0, then IDLE with all outputs 0.
- NUM_VOICES=4, all tone voices active, tick at t → `sample_valid` at t+5, t+10, t+15, t+20 with voices 0..3. `phase_we` at t+4, t+9, t+14, t+19. `sample_last` only at t+20.
- Voice 1 noise, voice 2 inactive:
  - voice 1: `en_osc_noise`/`s_osc_noise`=1 in its WAIT, `s_osc_out`=2, no `phase_we`;
  - voice 2: `s_osc_out`=0, no `phase_we`, no noise strobe.
- Tick at t+7 during a frame → `overrun`=1 at t+8. Frame still ends at t+20 and no second frame starts.
- `rst_n`=0 during a tone CAPTURE → no `phase_we` that cycle. After release: SEED, then IDLE with v=0.
- Back-to-back ticks at t and t+21 (first cycle of IDLE) → both frames run, no overrun.
